// File: rtl/tm_key_pkg.sv
// Shared defaults and helpers for the key conditioner.
// Counter widths and the per-key output bundle live here.
package tm_key_pkg;

   localparam int CLK_MHZ_DEF          = 27;
   localparam int W_KEY_DEF            = 8;
   localparam int DEBOUNCE_MS_DEF      = 10;
   localparam int REPEAT_DELAY_MS_DEF  = 500;
   localparam int REPEAT_PERIOD_MS_DEF = 100;

   typedef struct packed {
      logic state;
      logic pressed;
      logic released;
      logic rpt;
   } key_out_t;

   function automatic int cnt_w(input int n);
      int w;
      w = $clog2(n);
      return (w > 1) ? w : 1;
   endfunction

endpackage

// File: rtl/tm_key_cell.sv
// One key: input sample, debounce counter, stable level,
// edge pulses and auto-repeat hold counter.
module tm_key_cell
   import tm_key_pkg::*;
#(
   parameter int debounce_ms      = DEBOUNCE_MS_DEF,
   parameter int repeat_delay_ms  = REPEAT_DELAY_MS_DEF,
   parameter int repeat_period_ms = REPEAT_PERIOD_MS_DEF
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     tick,
   input  logic     raw,
   output key_out_t o_key
);

   localparam int DW = cnt_w(debounce_ms + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(debounce_ms - 1);
   localparam logic [DW-1:0] D_ONE   = DW'(1);

   logic          r_samp;
   logic          r_state;
   logic          r_pressed;
   logic          r_released;
   logic [DW-1:0] r_dcnt;

   logic w_diff;
   logic w_flip;
   logic w_rise;
   logic w_fall;
   logic w_rpt;

   assign w_diff = (r_samp != r_state);
   assign w_flip = w_diff && tick && (r_dcnt == DB_LAST);
   assign w_rise = w_flip & r_samp;
   assign w_fall = w_flip & ~r_samp;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_samp     <= 1'b0;
         r_state    <= 1'b0;
         r_dcnt     <= '0;
         r_pressed  <= 1'b0;
         r_released <= 1'b0;
      end else begin
         r_samp     <= raw;
         r_pressed  <= w_rise;
         r_released <= w_fall;
         if (!w_diff) begin
            r_dcnt <= '0;
         end else if (tick) begin
            if (r_dcnt == DB_LAST) begin
               r_state <= r_samp;
               r_dcnt  <= '0;
            end else begin
               r_dcnt <= r_dcnt + D_ONE;
            end
         end
      end
   end

   generate
      if (repeat_delay_ms > 0) begin : g_rpt
         localparam int HW = cnt_w(repeat_delay_ms + 1);
         localparam logic [HW-1:0] HC_LAST = HW'(repeat_delay_ms - 1);
         localparam logic [HW-1:0] HC_RLD  =
            HW'(repeat_delay_ms - repeat_period_ms);
         localparam logic [HW-1:0] H_ONE   = HW'(1);

         logic [HW-1:0] r_hcnt;
         logic          r_rpt;

         // A repeat that would land on the release edge is dropped.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_hcnt <= '0;
               r_rpt  <= 1'b0;
            end else if (!r_state || w_rise) begin
               r_hcnt <= '0;
               r_rpt  <= 1'b0;
            end else if (tick) begin
               if (r_hcnt == HC_LAST) begin
                  r_hcnt <= HC_RLD;
                  r_rpt  <= ~w_fall;
               end else begin
                  r_hcnt <= r_hcnt + H_ONE;
                  r_rpt  <= 1'b0;
               end
            end else begin
               r_rpt <= 1'b0;
            end
         end

         assign w_rpt = r_rpt;
      end else begin : g_norpt
         assign w_rpt = 1'b0;
      end
   endgenerate

   assign o_key.state    = r_state;
   assign o_key.pressed  = r_pressed;
   assign o_key.released = r_released;
   assign o_key.rpt      = w_rpt;

endmodule

// File: rtl/tm_key_conditioner.sv
// Key conditioner top: shared 1 ms prescaler feeding one
// debounce/repeat cell per key.
module tm_key_conditioner
   import tm_key_pkg::*;
#(
   parameter int clk_mhz          = CLK_MHZ_DEF,
   parameter int ms_div           = clk_mhz * 1000,
   parameter int w_key            = W_KEY_DEF,
   parameter int debounce_ms      = DEBOUNCE_MS_DEF,
   parameter int repeat_delay_ms  = REPEAT_DELAY_MS_DEF,
   parameter int repeat_period_ms = REPEAT_PERIOD_MS_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [w_key-1:0] key_raw,
   output logic [w_key-1:0] key_state,
   output logic [w_key-1:0] key_pressed,
   output logic [w_key-1:0] key_released,
   output logic [w_key-1:0] key_repeat,
   output logic             key_any
);

   localparam int PW = cnt_w(ms_div);
   localparam logic [PW-1:0] P_LAST = PW'(ms_div - 1);
   localparam logic [PW-1:0] P_ONE  = PW'(1);

   logic [PW-1:0] r_pcnt;
   logic          w_tick;
   key_out_t      w_cell [w_key];

   assign w_tick = (r_pcnt == P_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pcnt <= '0;
      end else if (w_tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + P_ONE;
      end
   end

   generate
      for (genvar g = 0; g < w_key; g++) begin : g_key
         tm_key_cell #(
            .debounce_ms      (debounce_ms),
            .repeat_delay_ms  (repeat_delay_ms),
            .repeat_period_ms (repeat_period_ms)
         ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (w_tick),
            .raw   (key_raw[g]),
            .o_key (w_cell[g])
         );

         assign key_state[g]    = w_cell[g].state;
         assign key_pressed[g]  = w_cell[g].pressed;
         assign key_released[g] = w_cell[g].released;
         assign key_repeat[g]   = w_cell[g].rpt;
      end
   endgenerate

   assign key_any = |key_state;

endmodule

// File: tb/tb_tm_key_conditioner.sv
// Directed bench for tm_key_conditioner with a 4-cycle tick,
// 3-tick debounce, 5-tick repeat delay and 2-tick repeat period.
module tb_tm_key_conditioner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] key_raw = 8'h00;
   logic [7:0] key_state;
   logic [7:0] key_pressed;
   logic [7:0] key_released;
   logic [7:0] key_repeat;
   logic       key_any;

   int checks = 0;
   int fails  = 0;
   int ecnt   = 0;

   always #5 clk = ~clk;

   tm_key_conditioner #(
      .ms_div           (4),
      .w_key            (8),
      .debounce_ms      (3),
      .repeat_delay_ms  (5),
      .repeat_period_ms (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_raw      (key_raw),
      .key_state    (key_state),
      .key_pressed  (key_pressed),
      .key_released (key_released),
      .key_repeat   (key_repeat),
      .key_any      (key_any)
   );

   function automatic logic [32:0] obs();
      return {key_state, key_pressed, key_released,
              key_repeat, key_any};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   task automatic do_reset(input logic [7:0] raw);
      rst_n   = 1'b0;
      key_raw = raw;
      repeat (2) step();
      rst_n = 1'b1;
      ecnt  = 0;
   endtask

   task automatic test_reset();
      logic [7:0]  st, pr;
      logic [32:0] exp;
      int          npress;
      rst_n   = 1'b0;
      key_raw = 8'hFF;
      repeat (3) begin
         step();
         checks++;
         if (obs() !== 33'h0) begin
            fails++;
            $display("FAIL reset_hold: got %h exp %h", obs(), 33'h0);
         end
      end
      rst_n  = 1'b1;
      ecnt   = 0;
      npress = 0;
      while (ecnt < 16) begin
         step();
         st  = (ecnt >= 12) ? 8'hFF : 8'h00;
         pr  = (ecnt == 12) ? 8'hFF : 8'h00;
         exp = {st, pr, 8'h00, 8'h00, |st};
         checks++;
         if (obs() !== exp) begin
            fails++;
            $display("FAIL reset_release e%0d: got %h exp %h",
                     ecnt, obs(), exp);
         end
         if (key_pressed != 8'h00) npress++;
      end
      checks++;
      if (npress != 1) begin
         fails++;
         $display("FAIL reset_press_count: got %0d exp 1", npress);
      end
   endtask

   task automatic test_press_release();
      logic [7:0]  st, pr, rl;
      logic [32:0] exp;
      do_reset(8'h00);
      while (ecnt < 32) begin
         step();
         st  = (ecnt >= 16 && ecnt < 28) ? 8'h01 : 8'h00;
         pr  = (ecnt == 16) ? 8'h01 : 8'h00;
         rl  = (ecnt == 28) ? 8'h01 : 8'h00;
         exp = {st, pr, rl, 8'h00, |st};
         checks++;
         if (obs() !== exp) begin
            fails++;
            $display("FAIL press_release e%0d: got %h exp %h",
                     ecnt, obs(), exp);
         end
         if (ecnt == 4)  key_raw = 8'h01;
         if (ecnt == 17) key_raw = 8'h00;
      end
   endtask

   task automatic test_glitch();
      logic [7:0]  st, pr;
      logic [32:0] exp;
      do_reset(8'h00);
      while (ecnt < 80) begin
         step();
         st  = (ecnt >= 72) ? 8'h04 : 8'h00;
         pr  = (ecnt == 72) ? 8'h04 : 8'h00;
         exp = {st, pr, 8'h00, 8'h00, |st};
         checks++;
         if (obs() !== exp) begin
            fails++;
            $display("FAIL glitch e%0d: got %h exp %h",
                     ecnt, obs(), exp);
         end
         if (ecnt < 60 && ecnt % 12 == 2) key_raw = 8'h04;
         if (ecnt < 60 && ecnt % 12 == 8) key_raw = 8'h00;
         if (ecnt == 62) key_raw = 8'h04;
      end
   endtask

   task automatic test_repeat();
      logic [7:0]  st, pr, rl, rp;
      logic [32:0] exp;
      int          nrep;
      do_reset(8'h00);
      nrep = 0;
      while (ecnt < 100) begin
         step();
         st = (ecnt >= 12 && ecnt < 72) ? 8'h20 : 8'h00;
         pr = (ecnt == 12) ? 8'h20 : 8'h00;
         rl = (ecnt == 72) ? 8'h20 : 8'h00;
         rp = (ecnt == 32 || ecnt == 40 || ecnt == 48 ||
               ecnt == 56 || ecnt == 64) ? 8'h20 : 8'h00;
         exp = {st, pr, rl, rp, |st};
         checks++;
         if (obs() !== exp) begin
            fails++;
            $display("FAIL repeat e%0d: got %h exp %h",
                     ecnt, obs(), exp);
         end
         if (key_repeat[5]) nrep++;
         if (ecnt == 2)  key_raw = 8'h20;
         if (ecnt == 62) key_raw = 8'h00;
      end
      checks++;
      if (nrep != 5) begin
         fails++;
         $display("FAIL repeat_count: got %0d exp 5", nrep);
      end
   endtask

   task automatic test_independent();
      logic [7:0]  st, pr, rl;
      logic [32:0] exp;
      do_reset(8'h40);
      while (ecnt < 40) begin
         step();
         if (ecnt < 12)      st = 8'h00;
         else if (ecnt < 24) st = 8'h40;
         else if (ecnt < 36) st = 8'h02;
         else                st = 8'h00;
         pr = (ecnt == 12) ? 8'h40 : (ecnt == 24) ? 8'h02 : 8'h00;
         rl = (ecnt == 24) ? 8'h40 : (ecnt == 36) ? 8'h02 : 8'h00;
         exp = {st, pr, rl, 8'h00, |st};
         checks++;
         if (obs() !== exp) begin
            fails++;
            $display("FAIL independent e%0d: got %h exp %h",
                     ecnt, obs(), exp);
         end
         if (ecnt == 13) key_raw = 8'h02;
         if (ecnt == 26) key_raw = 8'h00;
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0]  st, pr, rp;
      logic [32:0] exp;
      do_reset(8'h08);
      while (ecnt < 25) begin
         step();
         st  = (ecnt >= 12) ? 8'h08 : 8'h00;
         pr  = (ecnt == 12) ? 8'h08 : 8'h00;
         exp = {st, pr, 8'h00, 8'h00, |st};
         checks++;
         if (obs() !== exp) begin
            fails++;
            $display("FAIL mid_pre e%0d: got %h exp %h",
                     ecnt, obs(), exp);
         end
      end
      rst_n = 1'b0;
      step();
      checks++;
      if (obs() !== 33'h0) begin
         fails++;
         $display("FAIL mid_reset: got %h exp %h", obs(), 33'h0);
      end
      rst_n = 1'b1;
      ecnt  = 0;
      while (ecnt < 44) begin
         step();
         st  = (ecnt >= 12) ? 8'h08 : 8'h00;
         pr  = (ecnt == 12) ? 8'h08 : 8'h00;
         rp  = (ecnt == 32 || ecnt == 40) ? 8'h08 : 8'h00;
         exp = {st, pr, 8'h00, rp, |st};
         checks++;
         if (obs() !== exp) begin
            fails++;
            $display("FAIL mid_post e%0d: got %h exp %h",
                     ecnt, obs(), exp);
         end
      end
      key_raw = 8'h00;
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_glitch();
      test_repeat();
      test_independent();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
